// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
package booth_pkg;

   localparam int BOOTH_N_DEF = 8;

   // {Q[0], Q_prev} codes that require an arithmetic step before the shift
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      INIT  = 3'd2,
      CHECK = 3'd3,
      ADD   = 3'd4,
      SUB   = 3'd5,
      SHIFT = 3'd6,
      DONE  = 3'd7
   } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth sequencer; flags the final iteration (N-1).
module booth_iter_counter #(
   parameter int N     = 8,
   parameter int CNT_W = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic increment,
   output logic last
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (increment) begin
         count <= count + CNT_W'(1);
      end
   end

   assign last = (count == CNT_W'(N - 1));

endmodule

// File: rtl/booth_control_fsm.sv
// Control sequencer for the radix-2 Booth multiplier datapath.
// Optional abort input is enabled by defining BOOTH_ABORT_EN.
module booth_control_fsm
   import booth_pkg::*;
#(
   parameter int N     = BOOTH_N_DEF,
   parameter int CNT_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
`ifdef BOOTH_ABORT_EN
   input  logic       abort,
`endif
   input  logic [1:0] qo_qprev,
   output logic       load_M,
   output logic       load_Q,
   output logic       reset_A,
   output logic       reset_Qprev,
   output logic       add_M,
   output logic       subs_M,
   output logic       shift_all,
   output logic       busy,
   output logic       done,
   output state_t     dbg_state
);

   // Handshake: start is a request honoured only while busy is low; each
   // accepted request produces exactly one done pulse unless reset/abort.
   state_t state, state_nxt;
   logic   iter_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   booth_iter_counter #(
      .N     (N),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == INIT),
      .increment ((state == SHIFT) && !iter_last),
      .last      (iter_last)
   );

   always_comb begin
      state_nxt   = IDLE;
      load_M      = 1'b0;
      load_Q      = 1'b0;
      reset_A     = 1'b0;
      reset_Qprev = 1'b0;
      add_M       = 1'b0;
      subs_M      = 1'b0;
      shift_all   = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            state_nxt = start ? LOAD : IDLE;
         end
         LOAD: begin
            load_M    = 1'b1;
            load_Q    = 1'b1;
            state_nxt = INIT;
         end
         INIT: begin
            reset_A     = 1'b1;
            reset_Qprev = 1'b1;
            state_nxt   = CHECK;
         end
         CHECK: begin
            if (qo_qprev == BOOTH_ADD) begin
               state_nxt = ADD;
            end else if (qo_qprev == BOOTH_SUB) begin
               state_nxt = SUB;
            end else begin
               state_nxt = SHIFT;
            end
         end
         ADD: begin
            add_M     = 1'b1;
            state_nxt = SHIFT;
         end
         SUB: begin
            subs_M    = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            shift_all = 1'b1;
            state_nxt = iter_last ? DONE : CHECK;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
`ifdef BOOTH_ABORT_EN
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
      end
`endif
   end

   assign dbg_state = state;

endmodule
